// File: rtl/lcd_ctrl_pkg.sv
// Shared definitions for the serial LCD controller:
// register offsets, STATUS/CONTROL bit positions, FSM states.
package lcd_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CLKDIV  = 2'd2;
  localparam logic [1:0] ADDR_CONTROL = 2'd3;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_LVL   = 4;

  localparam int CT_EN    = 0;
  localparam int CT_RST   = 1;
  localparam int CT_IRQ   = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCL_HI,
    S_SCL_LO,
    S_HOLD,
    S_GAP
  } lcd_state_e;

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous command FIFO holding {A0,byte} entries.
// Ports: push_i/data_i write, pop_i/data_o read, full/empty/level status.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 9
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  // Extra pointer MSB separates full from empty.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lcd_serial_ctrl.sv
// Avalon-MM slave shifting queued {A0,byte} entries to a serial LCD.
// Ports: Avalon slave (address/chipselect/write_n/writedata/readdata), irq, LCD pins.
module lcd_serial_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 8,
  parameter int CLKDIV_RST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        lcd_si,
  output logic        lcd_scl,
  output logic        lcd_cs_n,
  output logic        lcd_a0,
  output logic        lcd_rst_n
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en, push, pop, full, empty;
  logic [8:0]    fifo_rd;
  logic [LW-1:0] level;
  logic          unused_wd;

  logic             ovf_q, ovf_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       ctrl_q, ctrl_d;
  lcd_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             si_q, si_d;
  logic             scl_q, scl_d;
  logic             csn_q, csn_d;
  logic             a0_q, a0_d;
  logic             tick;

  assign unused_wd = ^writedata;
  assign wr_en = chipselect && !write_n;
  assign push  = wr_en && (address == ADDR_DATA);

  lcd_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (writedata[8:0]),
    .pop_i   (pop),
    .data_o  (fifo_rd),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_comb begin
    ovf_d  = ovf_q;
    div_d  = div_q;
    ctrl_d = ctrl_q;
    // full is the pre-cycle flag: a write while full drops.
    if (push && full) ovf_d = 1'b1;
    if (wr_en) begin
      case (address)
        ADDR_STATUS:
          if (writedata[ST_OVF]) ovf_d = 1'b0;
        ADDR_CLKDIV:  div_d  = writedata[DIV_W-1:0];
        ADDR_CONTROL: ctrl_d = writedata[2:0];
        default: ;
      endcase
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    si_d    = si_q;
    scl_d   = scl_q;
    csn_d   = csn_q;
    a0_d    = a0_q;
    pop     = 1'b0;
    // Phases reload from CLKDIV on entry, so a new
    // divider never truncates the phase in progress.
    if (state_q != S_IDLE) begin
      if (tick) cnt_d = div_q;
      else      cnt_d = cnt_q - 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        csn_d = 1'b1;
        scl_d = 1'b0;
        if (ctrl_q[CT_EN] && !empty) begin
          pop     = 1'b1;
          sh_d    = fifo_rd[7:0];
          si_d    = fifo_rd[7];
          a0_d    = fifo_rd[8];
          csn_d   = 1'b0;
          bit_d   = 3'd0;
          cnt_d   = div_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP:
        if (tick) begin
          scl_d   = 1'b1;
          state_d = S_SCL_HI;
        end
      S_SCL_HI:
        if (tick) begin
          scl_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = S_HOLD;
          end else begin
            sh_d    = {sh_q[6:0], 1'b0};
            si_d    = sh_q[6];
            bit_d   = bit_q + 1'b1;
            state_d = S_SCL_LO;
          end
        end
      S_SCL_LO:
        if (tick) begin
          scl_d   = 1'b1;
          state_d = S_SCL_HI;
        end
      S_HOLD:
        if (tick) begin
          csn_d   = 1'b1;
          state_d = S_GAP;
        end
      S_GAP:
        if (tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q   <= 1'b0;
      div_q   <= DIV_W'(CLKDIV_RST);
      ctrl_q  <= 3'b010;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      si_q    <= 1'b0;
      scl_q   <= 1'b0;
      csn_q   <= 1'b1;
      a0_q    <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      si_q    <= si_d;
      scl_q   <= scl_d;
      csn_q   <= csn_d;
      a0_q    <= a0_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_STATUS: begin
        readdata[ST_BUSY]       = (state_q != S_IDLE);
        readdata[ST_FULL]       = full;
        readdata[ST_EMPTY]      = empty;
        readdata[ST_OVF]        = ovf_q;
        readdata[ST_LVL +: LW]  = level;
      end
      ADDR_CLKDIV:  readdata[DIV_W-1:0] = div_q;
      ADDR_CONTROL: readdata[2:0]       = ctrl_q;
      default: ;
    endcase
  end

  assign irq       = ctrl_q[CT_IRQ] && empty && (state_q == S_IDLE);
  assign lcd_si    = si_q;
  assign lcd_scl   = scl_q;
  assign lcd_cs_n  = csn_q;
  assign lcd_a0    = a0_q;
  assign lcd_rst_n = !ctrl_q[CT_RST];

endmodule

// File: tb/tb_lcd_serial_ctrl.sv
// Directed bench for lcd_serial_ctrl: register access,
// serial byte framing, divider timing, FIFO overflow and reset.
module tb_lcd_serial_ctrl;
  import lcd_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq, lcd_si, lcd_scl, lcd_cs_n, lcd_a0, lcd_rst_n;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  lcd_serial_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .lcd_si     (lcd_si),
    .lcd_scl    (lcd_scl),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_a0     (lcd_a0),
    .lcd_rst_n  (lcd_rst_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Line monitor, sampled on the falling clock edge.
  logic        scl_p = 1'b0, cs_p = 1'b1;
  logic [7:0]  sh = '0;
  logic        a0_first = 1'b0, a0_ok = 1'b1;
  int          nb = 0, rise_cnt = 0, hi_run = 0, low_run = 0;
  logic [15:0] byte_q[$];
  int          hi_q[$], fall_q[$], low_q[$];

  always @(negedge clk) begin
    if (reset) begin
      hi_run = 0;
      low_run = 0;
      nb = 0;
    end else begin
      if (lcd_scl) hi_run++;
      if (lcd_scl && !scl_p) begin
        rise_cnt++;
        sh = {sh[6:0], lcd_si};
        nb++;
        if (nb == 1) a0_first = lcd_a0;
        else if (lcd_a0 !== a0_first) a0_ok = 1'b0;
      end
      if (!lcd_scl && scl_p) begin
        hi_q.push_back(hi_run);
        hi_run = 0;
      end
      if (!lcd_cs_n && cs_p) begin
        fall_q.push_back(cyc);
        nb = 0;
        a0_ok = 1'b1;
        low_run = 0;
      end
      if (!lcd_cs_n) low_run++;
      if (lcd_cs_n && !cs_p) begin
        byte_q.push_back({2'b0, a0_ok, a0_first, 4'(nb), sh});
        low_q.push_back(low_run);
      end
    end
    scl_p = lcd_scl;
    cs_p  = lcd_cs_n;
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    logic [31:0] s;
    logic done;
    done = 1'b0;
    for (int i = 0; i < max && !done; i++) begin
      rd(ADDR_STATUS, s);
      if (!s[ST_BUSY] && s[ST_EMPTY]) done = 1'b1;
    end
    chk({tag, "_idle_timeout"}, done, 1'b1);
  endtask

  task automatic wait_rises(input string tag, input int n);
    int base;
    base = rise_cnt;
    for (int i = 0; i < 2000 && (rise_cnt - base) < n; i++) tick();
    chk({tag, "_rise_timeout"}, (rise_cnt - base) >= n, 1'b1);
  endtask

  task automatic check_byte(input string tag, input logic [8:0] exp);
    logic [15:0] e;
    if (byte_q.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      e = byte_q.pop_front();
      chk({tag, "_data"}, e[7:0], exp[7:0]);
      chk({tag, "_nbits"}, e[11:8], 4'd8);
      chk({tag, "_a0"}, e[12], exp[8]);
      chk({tag, "_a0_steady"}, e[13], 1'b1);
    end
  endtask

  task automatic clear_mon();
    byte_q.delete();
    hi_q.delete();
    fall_q.delete();
    low_q.delete();
  endtask

  task automatic hi_range(input string tag, input int lo_i, input int hi_i,
                          input int exp);
    int bad;
    bad = 0;
    for (int i = lo_i; i <= hi_i; i++)
      if (i >= hi_q.size() || hi_q[i] != exp) bad++;
    chk({tag, "_scl_hi_len_bad"}, bad, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int base;
    reset = 1'b1; address = '0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state
    rd(ADDR_STATUS, d);  chk("t1_status", d, 32'h04);
    rd(ADDR_CLKDIV, d);  chk("t1_clkdiv", d, 32'h4);
    rd(ADDR_CONTROL, d); chk("t1_control", d, 32'h2);
    rd(ADDR_DATA, d);    chk("t1_data_rd", d, 32'h0);
    chk("t1_cs_n", lcd_cs_n, 1'b1);
    chk("t1_rst_n", lcd_rst_n, 1'b0);
    chk("t1_scl", lcd_scl, 1'b0);
    chk("t1_si", lcd_si, 1'b0);
    chk("t1_a0", lcd_a0, 1'b0);
    chk("t1_irq", irq, 1'b0);

    // 2: H=1, single command byte 0xA5
    wr(ADDR_CLKDIV, 32'd0);
    wr(ADDR_CONTROL, 32'h1);
    chk("t2_rst_n", lcd_rst_n, 1'b1);
    clear_mon();
    wr(ADDR_DATA, 32'h0A5);
    wait_idle("t2", 200);
    check_byte("t2_b0", 9'h0A5);
    chk("t2_cs_low_len", low_q.size() > 0 ? low_q[0] : -1, 17);
    hi_range("t2", 0, 7, 1);

    // 3: H=4, two bytes back to back
    wr(ADDR_CLKDIV, 32'd3);
    clear_mon();
    wr(ADDR_DATA, 32'h1FF);
    wr(ADDR_DATA, 32'h000);
    wait_idle("t3", 400);
    check_byte("t3_b0", 9'h1FF);
    check_byte("t3_b1", 9'h000);
    chk("t3_byte_period",
        fall_q.size() == 2 ? fall_q[1] - fall_q[0] : -1, 18 * 4 + 1);
    chk("t3_cs_low_len", low_q.size() > 0 ? low_q[0] : -1, 17 * 4);
    hi_range("t3", 0, 15, 4);

    // 4: overflow with FIFO held (enable off)
    wr(ADDR_CONTROL, 32'h0);
    clear_mon();
    for (int i = 0; i < 5; i++) wr(ADDR_DATA, 32'h011 + i);
    rd(ADDR_STATUS, d);  chk("t4_status_ovf", d, 32'h4A);
    wr(ADDR_STATUS, 32'h8);
    rd(ADDR_STATUS, d);  chk("t4_status_clr", d, 32'h42);
    wr(ADDR_CONTROL, 32'h4);
    chk("t4_irq_nonempty", irq, 1'b0);
    wr(ADDR_CONTROL, 32'h1);
    wait_idle("t4", 2000);
    chk("t4_nbytes", byte_q.size(), 4);
    check_byte("t4_b0", 9'h011);
    check_byte("t4_b1", 9'h012);
    check_byte("t4_b2", 9'h013);
    check_byte("t4_b3", 9'h014);
    wr(ADDR_CONTROL, 32'h5);
    chk("t4_irq_idle", irq, 1'b1);
    wr(ADDR_CONTROL, 32'h1);
    chk("t4_irq_off", irq, 1'b0);

    // 5: divider change mid-byte
    clear_mon();
    wr(ADDR_DATA, 32'h0C3);
    wr(ADDR_DATA, 32'h13C);
    wait_rises("t5", 2);
    wr(ADDR_CLKDIV, 32'd7);
    wait_idle("t5", 2000);
    check_byte("t5_b0", 9'h0C3);
    check_byte("t5_b1", 9'h13C);
    hi_range("t5_old", 0, 1, 4);
    hi_range("t5_new", 2, 7, 8);
    hi_range("t5_b1", 8, 15, 8);
    chk("t5_b1_cs_low", low_q.size() == 2 ? low_q[1] : -1, 17 * 8);

    // 6: reset during SCL high of the fourth bit
    wr(ADDR_CLKDIV, 32'd3);
    clear_mon();
    wr(ADDR_DATA, 32'h0F0);
    wr(ADDR_DATA, 32'h055);
    wait_rises("t6", 4);
    chk("t6_in_scl_hi", lcd_scl, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_cs_n", lcd_cs_n, 1'b1);
    chk("t6_scl", lcd_scl, 1'b0);
    chk("t6_si", lcd_si, 1'b0);
    chk("t6_a0", lcd_a0, 1'b0);
    chk("t6_rst_n", lcd_rst_n, 1'b0);
    chk("t6_irq", irq, 1'b0);
    reset = 1'b0;
    rd(ADDR_STATUS, d);  chk("t6_status", d, 32'h04);
    rd(ADDR_CLKDIV, d);  chk("t6_clkdiv", d, 32'h4);
    base = rise_cnt;
    repeat (100) tick();
    chk("t6_no_scl", rise_cnt - base, 0);
    chk("t6_no_bytes", byte_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
